// File: rtl/dds_pkg.sv
// Shared encodings for the multi-channel DDS: output modes, cfg register
// selects and the config FSM state type.
package dds_pkg;

  // Output mode encoding (MODE register bits [1:0])
  localparam logic [1:0] MODE_COS_S = 2'd0;  // signed cosine
  localparam logic [1:0] MODE_COS_U = 2'd1;  // offset-binary cosine
  localparam logic [1:0] MODE_SQR   = 2'd2;  // square, +/- max
  localparam logic [1:0] MODE_SAW   = 2'd3;  // raw phase sawtooth

  // cfg_sel encoding; 2'd3 is reserved and writes to it are dropped
  localparam logic [1:0] SEL_FTW  = 2'd0;
  localparam logic [1:0] SEL_POW  = 2'd1;
  localparam logic [1:0] SEL_MODE = 2'd2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/cos_quarter_lut.sv
// Quarter-wave cosine ROM with a registered read port. Holds entries
// 0..Q (Q = 2^(ADDR_W-2)) so the fold logic can mirror without a special case.
module cos_quarter_lut #(
  parameter int ADDR_W = 10,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-2:0] idx_i,
  output logic [OUT_W-1:0]  data_o
);
  localparam int Q = 1 << (ADDR_W - 2);

  // Elaboration-time cosine via Taylor series, rounded to the nearest code.
  function automatic int lut_val(input int k);
    real x, term, sum;
    x    = 2.0 * 3.14159265358979 * real'(k) / real'(1 << ADDR_W);
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n < 16; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    if (sum < 0.0) sum = 0.0;
    return $rtoi(sum * real'((1 << (OUT_W - 1)) - 1) + 0.5);
  endfunction

  logic [OUT_W-1:0] rom [0:Q];

  for (genvar k = 0; k <= Q; k++) begin : g_rom
    localparam int V = lut_val(k);
    assign rom[k] = OUT_W'(V);
  end

  // Registered read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_o <= '0;
    else        data_o <= rom[idx_i];
  end

endmodule

// File: rtl/dds_multi_gen.sv
// Multi-channel DDS: per-channel phase accumulator, 3-stage phase-to-sample
// pipeline (offset/address, quarter-wave LUT, sign+mode), and a shared
// double-buffered config port committed atomically by update.
//
// cfg handshake: a write transfers on a rising clk edge where
// cfg_valid && cfg_ready; cfg_ready is high in IDLE only (low in the
// single COMMIT cycle and while rst_n is low), data/ch/sel are sampled
// at that edge and the requester may change them afterwards.
module dds_multi_gen
  import dds_pkg::*;
#(
  parameter int          NUM_CH      = 2,
  parameter int          ACC_W       = 32,
  parameter int          ADDR_W      = 10,
  parameter int          OUT_W       = 8,
  parameter logic [31:0] DEFAULT_FTW = 32'd429497,
  localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    phase_clr,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [1:0]              cfg_sel,
  input  logic [ACC_W-1:0]        cfg_data,
  input  logic                    update,
  output logic [NUM_CH*OUT_W-1:0] dout,
  output logic                    dout_valid,
  output logic [NUM_CH-1:0]       wrap,
  output cfg_state_e              dbg_cfg_state
);
  localparam int               IDX_W = ADDR_W - 1;
  localparam int               Q     = 1 << (ADDR_W - 2);
  localparam logic [OUT_W-1:0] MAX_P = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MAX_N = ~MAX_P + OUT_W'(1);
  localparam logic [OUT_W-1:0] OFFS  = {1'b1, {(OUT_W-1){1'b0}}};

  cfg_state_e       state_q;
  logic [ACC_W-1:0] ftw_sh_q  [NUM_CH];
  logic [ACC_W-1:0] pow_sh_q  [NUM_CH];
  logic [1:0]       mode_sh_q [NUM_CH];
  logic [ACC_W-1:0] ftw_q     [NUM_CH];
  logic [ACC_W-1:0] pow_q     [NUM_CH];
  logic [1:0]       mode_q    [NUM_CH];
  logic [2:0]       vld_sr_q;

  // Reset gates ready combinationally so it is low for the whole reset.
  assign cfg_ready     = rst_n && (state_q == ST_IDLE);
  assign dbg_cfg_state = state_q;
  assign dout_valid    = vld_sr_q[2];

  // Config FSM: shadow writes in IDLE, one-cycle atomic commit in COMMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      for (int k = 0; k < NUM_CH; k++) begin
        ftw_sh_q[k]  <= ACC_W'(DEFAULT_FTW);
        pow_sh_q[k]  <= '0;
        mode_sh_q[k] <= MODE_COS_U;
        ftw_q[k]     <= ACC_W'(DEFAULT_FTW);
        pow_q[k]     <= '0;
        mode_q[k]    <= MODE_COS_U;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_valid) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (cfg_ch == CH_W'(k)) begin
                case (cfg_sel)
                  SEL_FTW:  ftw_sh_q[k]  <= cfg_data;
                  SEL_POW:  pow_sh_q[k]  <= cfg_data;
                  SEL_MODE: mode_sh_q[k] <= cfg_data[1:0];
                  default:  ;
                endcase
              end
            end
          end
          if (update) state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          for (int k = 0; k < NUM_CH; k++) begin
            ftw_q[k]  <= ftw_sh_q[k];
            pow_q[k]  <= pow_sh_q[k];
            mode_q[k] <= mode_sh_q[k];
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sample-valid tracks en through the 3-stage pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_sr_q <= '0;
    else        vld_sr_q <= {vld_sr_q[1:0], en};
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [ACC_W-1:0]  acc_q, s1_phase_q;
    logic [ACC_W:0]    acc_sum;
    logic              wrap_q, s2_neg_q;
    logic [1:0]        s1_mode_q, s2_mode_q;
    logic [OUT_W-1:0]  s2_top_q, lut_data, signed_val, out_d, dout_q;
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  lut_idx;
    logic              unused_phase_lo;

    assign acc_sum = {1'b0, acc_q} + {1'b0, ftw_q[k]};

    // Phase accumulator; carry-out gives the wrap pulse
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q  <= '0;
        wrap_q <= 1'b0;
      end else if (phase_clr) begin
        acc_q  <= '0;
        wrap_q <= 1'b0;
      end else if (en) begin
        acc_q  <= acc_sum[ACC_W-1:0];
        wrap_q <= acc_sum[ACC_W];
      end else begin
        wrap_q <= 1'b0;
      end
    end

    // S1: apply phase offset, capture mode alongside the phase
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_phase_q <= '0;
        s1_mode_q  <= '0;
      end else begin
        s1_phase_q <= acc_q + pow_q[k];
        s1_mode_q  <= mode_q[k];
      end
    end

    // Fold the full-cycle address onto the quarter wave; odd quadrants mirror
    assign addr    = s1_phase_q[ACC_W-1 -: ADDR_W];
    assign lut_idx = addr[ADDR_W-2] ? (IDX_W'(Q) - {1'b0, addr[ADDR_W-3:0]})
                                    : {1'b0, addr[ADDR_W-3:0]};
    assign unused_phase_lo = ^s1_phase_q[ACC_W-ADDR_W-1:0];

    cos_quarter_lut #(.ADDR_W(ADDR_W), .OUT_W(OUT_W)) u_lut (
      .clk    (clk),
      .rst_n  (rst_n),
      .idx_i  (lut_idx),
      .data_o (lut_data)
    );

    // S2: side-band fields that travel with the LUT read
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_neg_q  <= 1'b0;
        s2_mode_q <= '0;
        s2_top_q  <= '0;
      end else begin
        s2_neg_q  <= addr[ADDR_W-1] ^ addr[ADDR_W-2];
        s2_mode_q <= s1_mode_q;
        s2_top_q  <= s1_phase_q[ACC_W-1 -: OUT_W];
      end
    end

    assign signed_val = s2_neg_q ? (~lut_data + OUT_W'(1)) : lut_data;

    // S3 mode select
    always_comb begin
      out_d = signed_val;
      case (s2_mode_q)
        MODE_COS_S: out_d = signed_val;
        MODE_COS_U: out_d = signed_val + OFFS;
        MODE_SQR:   out_d = s2_top_q[OUT_W-1] ? MAX_N : MAX_P;
        MODE_SAW:   out_d = s2_top_q;
        default:    out_d = signed_val;
      endcase
    end

    // S3 output register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= '0;
      else        dout_q <= out_d;
    end

    assign dout[k*OUT_W +: OUT_W] = dout_q;
    assign wrap[k]                = wrap_q;
  end

endmodule

// File: tb/tb_dds_multi_gen.sv
// Directed bench for dds_multi_gen: expected samples are queued by the
// driver, a negedge monitor pops one per valid output sample.
module tb_dds_multi_gen;
  import dds_pkg::*;

  localparam logic [31:0] DEF = 32'd429497;
  localparam logic [31:0] F30 = 32'h4000_0000;
  localparam logic [31:0] F31 = 32'h8000_0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en = 0, phase_clr = 0, cfg_valid = 0, update = 0;
  logic        cfg_ready;
  logic [0:0]  cfg_ch = '0;
  logic [1:0]  cfg_sel = '0;
  logic [31:0] cfg_data = '0;
  logic [15:0] dout;
  logic        dout_valid;
  logic [1:0]  wrap;
  cfg_state_e  dbg_state;

  dds_multi_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .phase_clr(phase_clr),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .update(update),
    .dout(dout), .dout_valid(dout_valid), .wrap(wrap),
    .dbg_cfg_state(dbg_state)
  );

  // scoreboard
  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        mon_skip = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // monitor: one expected sample per valid output
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n && dout_valid && !mon_skip) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sample_extra actual=%h required=none", dout);
      end else begin
        e = exp_q.pop_front();
        check("sample", 32'(dout), 32'(e));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // c1/c0 hold four consecutive 8-bit samples, first sample in the top byte
  task automatic push_pat(input logic [31:0] c1, input logic [31:0] c0, input int reps);
    for (int i = 0; i < reps * 4; i++)
      exp_q.push_back({c1[8*(3-(i%4)) +: 8], c0[8*(3-(i%4)) +: 8]});
  endtask

  task automatic cfg_write(input logic ch, input logic [1:0] sel, input logic [31:0] d,
                           input logic upd);
    cfg_ch = ch; cfg_sel = sel; cfg_data = d; cfg_valid = 1'b1; update = upd;
    check("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0; update = 1'b0;
  endtask

  task automatic commit(input logic hold);
    update = 1'b1;
    tick();
    update = hold;
    check("ready_in_commit", 32'(cfg_ready), 32'd0);
    tick();
    update = 1'b0;
    check("ready_after_commit", 32'(cfg_ready), 32'd1);
  endtask

  // clear phase, then n enabled cycles with wrap checked against carry model
  task automatic run(input int n, input logic [31:0] f0, input logic [31:0] f1);
    logic [31:0] a0, a1;
    logic [32:0] s0, s1;
    phase_clr = 1'b1;
    tick();
    phase_clr = 1'b0;
    check("wrap_after_clr", 32'(wrap), 32'd0);
    a0 = '0; a1 = '0;
    en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      s0 = {1'b0, a0} + {1'b0, f0};
      s1 = {1'b0, a1} + {1'b0, f1};
      a0 = s0[31:0];
      a1 = s1[31:0];
      check("wrap", 32'(wrap), 32'({s1[32], s0[32]}));
    end
    en = 1'b0;
    tick();
    check("wrap_idle", 32'(wrap), 32'd0);
    repeat (4) tick();
  endtask

  initial begin
    // reset defaults
    repeat (3) tick();
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_release", 32'(cfg_ready), 32'd1);

    push_pat(32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    en = 1'b1;
    tick(); check("valid_c1", 32'(dout_valid), 32'd0);
    tick(); check("valid_c2", 32'(dout_valid), 32'd0);
    tick(); check("valid_c3", 32'(dout_valid), 32'd1);
    tick();
    en = 1'b0;
    repeat (4) tick();

    // default FTW: first carry on the 10000th enabled edge
    mon_skip = 1'b1;
    run(10001, DEF, DEF);
    mon_skip = 1'b0;

    // quarter-rate signed cosine on ch0
    cfg_write(1'b0, SEL_FTW, F30, 1'b0);
    cfg_write(1'b0, SEL_MODE, 32'd0, 1'b0);
    commit(1'b0);
    push_pat(32'hFFFFFFFF, 32'h7F008100, 2);
    run(8, F30, DEF);

    // double buffering: shadow write to ch1 has no effect before commit
    cfg_write(1'b1, SEL_FTW, F31, 1'b0);
    cfg_write(1'b1, SEL_MODE, 32'd0, 1'b0);
    push_pat(32'hFFFFFFFF, 32'h7F008100, 5);
    run(20, F30, DEF);
    commit(1'b1);  // update held into COMMIT must not re-commit
    push_pat(32'h7F817F81, 32'h7F008100, 2);
    run(8, F30, F31);

    // reserved select ignored; MODE write together with update is committed
    cfg_write(1'b1, 2'd3, 32'h0000_5555, 1'b0);
    cfg_write(1'b0, SEL_MODE, 32'd2, 1'b1);
    check("ready_in_commit_wr", 32'(cfg_ready), 32'd0);
    tick();
    check("ready_after_commit_wr", 32'(cfg_ready), 32'd1);
    push_pat(32'h7F817F81, 32'h7F7F8181, 2);
    run(8, F30, F31);

    // phase offset on ch0, all-ones FTW sawtooth on ch1
    cfg_write(1'b0, SEL_POW, F31, 1'b0);
    cfg_write(1'b0, SEL_MODE, 32'd0, 1'b0);
    cfg_write(1'b1, SEL_FTW, 32'hFFFF_FFFF, 1'b0);
    cfg_write(1'b1, SEL_MODE, 32'd3, 1'b0);
    commit(1'b0);
    push_pat(32'h00FFFFFF, 32'h81007F00, 1);
    push_pat(32'hFFFFFFFF, 32'h81007F00, 1);
    run(8, F30, 32'hFFFF_FFFF);

    // reset during COMMIT discards the pending commit
    mon_skip = 1'b1;
    en = 1'b1;
    repeat (4) tick();
    cfg_write(1'b0, SEL_FTW, F31, 1'b0);
    cfg_write(1'b0, SEL_MODE, 32'd0, 1'b1);
    check("state_commit", 32'(dbg_state), 32'(ST_COMMIT));
    rst_n = 1'b0;
    #1;
    check("async_dout", 32'(dout), 32'd0);
    check("async_valid", 32'(dout_valid), 32'd0);
    check("async_ready", 32'(cfg_ready), 32'd0);
    en = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("ready_rerelease", 32'(cfg_ready), 32'd1);
    mon_skip = 1'b0;
    push_pat(32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    run(4, DEF, DEF);
    commit(1'b0);  // shadows must also be back at defaults
    push_pat(32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    run(4, DEF, DEF);

    repeat (5) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dds_multi_gen.md
Name: dds_multi_gen

Overview:
Parametrised multi-channel direct digital synthesiser. It is the successor to the team's fixed two-tone cosine generator. Each channel has its own phase accumulator, a programmable frequency tuning word (FTW), a phase offset word (POW) and an output mode. A shared cfg port writes double-buffered shadow registers, which are committed atomically. The block feeds the modulator and DAC paths of the signal-generation chain.

Parameters:
NUM_CH, 2, number of independent channels
ACC_W, 32, phase accumulator width
ADDR_W, 10, full-cycle waveform address width; the LUT stores one quarter wave, 2^(ADDR_W-2)+1 entries
OUT_W, 8, sample width per channel
DEFAULT_FTW, 32'd429497, FTW loaded into every channel at reset (10 kHz at 100 MHz)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  accumulators advance only while high
phase_clr  in  1  zeroes all accumulators
cfg_valid  in  1  cfg write request
cfg_ready  out  1  cfg write accepted when valid&ready
cfg_ch  in  max(1,$clog2(NUM_CH))  target channel
cfg_sel  in  2  0=FTW, 1=POW, 2=MODE, 3=reserved (write ignored)
cfg_data  in  ACC_W  write data; MODE uses bits [1:0]
update  in  1  commit all shadow registers to the active registers
dout  out  NUM_CH*OUT_W  channel k is at [k*OUT_W +: OUT_W]
dout_valid  out  1  dout holds a valid pipelined sample
wrap  out  NUM_CH  one-cycle pulse per channel on accumulator carry-out

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous and active-low.
- Reset values:
  - acc = 0; shadow and active FTW = DEFAULT_FTW; POW = 0; MODE = 1.
  - dout = 0, dout_valid = 0, wrap = 0, cfg_ready = 1 after release. cfg_ready is 0 while rst_n is low.
- Accumulator:
  - If phase_clr: acc <= 0 and wrap <= 0. phase_clr has priority over en.
  - Else if en: acc <= acc + FTW_active, modulo 2^ACC_W; wrap[k] <= carry-out.
  - Else acc holds and wrap <= 0.
- Pipeline, with a fixed latency of 3 clocks from an acc register value to dout:
  - S1 (registered): phase = acc + POW_active, modulo 2^ACC_W; addr = phase[ACC_W-1 -: ADDR_W].
  - Fold: quadrant q = addr[ADDR_W-1:ADDR_W-2], idx = low bits, Q = 2^(ADDR_W-2).
  - S2 (registered): cos_quarter_lut read. q0 uses LUT[idx], q1 uses LUT[Q-idx], q2 uses LUT[idx], q3 uses LUT[Q-idx]. The negate flag is set for q1 and q2 and is carried forward.
  - S3 (registered): apply negation, then mode. MODE and phase are pipelined so all fields align with their sample.
- LUT contents: round(cos(2*pi*k/2^ADDR_W) * (2^(OUT_W-1)-1)) for k = 0..Q, signed.
- Modes:
  - 0: signed cosine.
  - 1: offset-binary cosine (signed value + 2^(OUT_W-1)).
  - 2: square, +max when phase MSB = 0, else -max.
  - 3: sawtooth, raw phase[ACC_W-1 -: OUT_W].
- dout_valid: en delayed 3 cycles through a shift register. phase_clr does not clear dout_valid.
- Config FSM, states IDLE and COMMIT:
  - IDLE: cfg_ready = 1. An accepted write updates shadow[cfg_ch][cfg_sel]. update moves to COMMIT.
  - COMMIT (exactly 1 cycle): all active registers <= shadows simultaneously; cfg_ready = 0; then return to IDLE.
  - The new FTW affects acc in the cycle after COMMIT.
  - A write accepted in the same cycle as update is included in the commit.
  - update asserted during COMMIT is ignored.
  - cfg_ch >= NUM_CH: write accepted, no effect.
- Reset asserted mid-operation, including during COMMIT: every register returns immediately to its reset value and the pending commit is lost.

Decomposition:
- Package dds_pkg holds:
  - the mode encoding: MODE_COS_S=0, MODE_COS_U=1, MODE_SQR=2, MODE_SAW=3;
  - the cfg_sel encodings: SEL_FTW, SEL_POW, SEL_MODE;
  - the IDLE/COMMIT state type.
- One sub-module, cos_quarter_lut: registered read with one port per channel (or a replicated instance per channel), parametrised by ADDR_W and OUT_W.

Test Plan:
- Reset defaults: release rst_n, en=1, no cfg -> dout_valid rises on cycle 3. ch0 first sample = 255 (127+128, mode 1). ch0 wrap pulses about every 10000 cycles.
- Quarter-rate cosine: ch0 FTW=2^30, MODE=0, update, en=1 -> dout ch0 repeats 127, 0, -127, 0. wrap[0] pulses every 4th cycle.
- Double buffering: write ch1 FTW=2^31 without update -> ch1 output unchanged for 20 cycles. Pulse update -> cfg_ready=0 for exactly 1 cycle; ch1 follows the 127/-127 pattern with 3-cycle latency after commit.
- Write plus update in the same cycle: write ch0 MODE=2 and update together -> mode 2 is active; square output +127/-127 with the period set by the FTW.
- phase_clr with offset: ch0 POW=2^31, MODE=0, pulse phase_clr -> three cycles later ch0 = -127. Also verify 0xFFFFFFFF FTW wraps modulo 2^32 with no stall.
- Reset during COMMIT: drop rst_n in the COMMIT cycle -> dout=0, dout_valid=0, cfg_ready=0 asynchronously. After release, FTW=DEFAULT_FTW and MODE=1; the pending commit is discarded.
